qdec_flag_tu_fsm: RTL

Parametrised CABAC sub-FSM. It decodes an optional context-coded flag, then a truncated-unary index with a runtime cMax. It sits between a syntax-level parent FSM and the shared arithmetic decoder. It generalises the single-purpose flag-plus-index sub-FSMs (chroma QP offset, and similar) with these additions:

- configurable index width;
- per-bin context selection;
- bypass-coded tail bins;
- a decoder-ready handshake;
- registered result outputs.

---
 rtl/qdec_flag_tu_fsm.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/qdec_flag_tu_fsm.sv
// CABAC sub-FSM: optional context-coded flag followed by a truncated-unary index
// with runtime cMax, per-bin context selection and bypass-coded tail bins.
module qdec_flag_tu_fsm #(
    parameter int IDX_W        = 3,
    parameter int CTX_W        = 10,
    parameter int FLAG_CTX     = 0,
    parameter int IDX_CTX_BASE = 0,
    parameter int IDX_CTX_NUM  = 1,
    parameter int EP_FROM      = 2**IDX_W - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flag_en,
    input  logic [IDX_W-1:0] idx_cmax,
    output logic [CTX_W-1:0] ctx_addr,
    output logic             ctx_addr_vld,
    output logic             dec_run,
    output logic             ep_mode,
    input  logic             dec_rdy,
    input  logic             bin,
    input  logic             bin_vld,
    output logic             flag_out,
    output logic [IDX_W-1:0] idx_out,
    output logic             result_vld,
    output logic             done_intr,
    output logic             busy
);

    // Offsets beyond the last index context all share it; clamp to the counter range.
    localparam int LAST_OFS = (IDX_CTX_NUM < 1) ? 0 :
                              ((IDX_CTX_NUM - 1 > 2**IDX_W - 1) ? 2**IDX_W - 1 : IDX_CTX_NUM - 1);
    localparam int EP_CLAMP = (EP_FROM < 0) ? 0 :
                              ((EP_FROM > 2**IDX_W) ? 2**IDX_W : EP_FROM);

    localparam logic [IDX_W-1:0] LAST_OFS_C = IDX_W'(LAST_OFS);
    localparam logic [IDX_W:0]   EP_FROM_C  = (IDX_W+1)'(EP_CLAMP);
    localparam logic [CTX_W-1:0] FLAG_CTX_C = CTX_W'(FLAG_CTX);
    localparam logic [CTX_W-1:0] IDX_BASE_C = CTX_W'(IDX_CTX_BASE);
    localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FLAG_REQ  = 3'd1,
        ST_FLAG_WAIT = 3'd2,
        ST_IDX_REQ   = 3'd3,
        ST_IDX_WAIT  = 3'd4,
        ST_ENDING    = 3'd5
    } state_t;

    function automatic logic [CTX_W-1:0] idx_ctx(input logic [IDX_W-1:0] k);
        logic [IDX_W-1:0] ofs;
        ofs = (k > LAST_OFS_C) ? LAST_OFS_C : k;
        return IDX_BASE_C + CTX_W'(ofs);
    endfunction

    function automatic logic idx_bypass(input logic [IDX_W-1:0] k);
        return ({1'b0, k} >= EP_FROM_C);
    endfunction

    state_t           state_r;
    logic [IDX_W-1:0] cmax_r;
    logic             flag_reg_r;
    logic [IDX_W-1:0] idx_reg_r;
    logic [IDX_W-1:0] k_r;
    logic             busy_r;
    logic [CTX_W-1:0] ctx_addr_r;
    logic             ctx_addr_vld_r;
    logic             dec_run_r;
    logic             ep_mode_r;
    logic             flag_out_r;
    logic [IDX_W-1:0] idx_out_r;
    logic             result_vld_r;
    logic             done_intr_r;
    logic [IDX_W-1:0] idx_inc_s;

    assign idx_inc_s = idx_reg_r + IDX_ONE;

    // Sequencer: issues one decoder request at a time and registers every output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            cmax_r         <= IDX_ZERO;
            flag_reg_r     <= 1'b0;
            idx_reg_r      <= IDX_ZERO;
            k_r            <= IDX_ZERO;
            busy_r         <= 1'b0;
            ctx_addr_r     <= {CTX_W{1'b0}};
            ctx_addr_vld_r <= 1'b0;
            dec_run_r      <= 1'b0;
            ep_mode_r      <= 1'b0;
            flag_out_r     <= 1'b0;
            idx_out_r      <= IDX_ZERO;
            result_vld_r   <= 1'b0;
            done_intr_r    <= 1'b0;
        end else begin
            ctx_addr_vld_r <= 1'b0;
            dec_run_r      <= ctx_addr_vld_r;
            result_vld_r   <= 1'b0;
            done_intr_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // busy_r is still high in the result cycle, so a start there is dropped.
                    if (start && !busy_r) begin
                        cmax_r     <= idx_cmax;
                        flag_reg_r <= 1'b0;
                        idx_reg_r  <= IDX_ZERO;
                        k_r        <= IDX_ZERO;
                        busy_r     <= 1'b1;
                        state_r    <= flag_en ? ST_FLAG_REQ : ST_ENDING;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_FLAG_REQ: begin
                    if (dec_rdy) begin
                        ctx_addr_r     <= FLAG_CTX_C;
                        ep_mode_r      <= 1'b0;
                        ctx_addr_vld_r <= 1'b1;
                        state_r        <= ST_FLAG_WAIT;
                    end
                end
                ST_FLAG_WAIT: begin
                    if (bin_vld) begin
                        flag_reg_r <= bin;
                        state_r    <= (bin && (cmax_r != IDX_ZERO)) ? ST_IDX_REQ : ST_ENDING;
                    end
                end
                ST_IDX_REQ: begin
                    if (dec_rdy) begin
                        ctx_addr_r     <= idx_ctx(k_r);
                        ep_mode_r      <= idx_bypass(k_r);
                        ctx_addr_vld_r <= 1'b1;
                        state_r        <= ST_IDX_WAIT;
                    end
                end
                ST_IDX_WAIT: begin
                    if (bin_vld) begin
                        if (bin) begin
                            idx_reg_r <= idx_inc_s;
                            k_r       <= k_r + IDX_ONE;
                            state_r   <= (idx_inc_s == cmax_r) ? ST_ENDING : ST_IDX_REQ;
                        end else begin
                            state_r <= ST_ENDING;
                        end
                    end
                end
                ST_ENDING: begin
                    flag_out_r   <= flag_reg_r;
                    idx_out_r    <= idx_reg_r;
                    result_vld_r <= 1'b1;
                    done_intr_r  <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ctx_addr     = ctx_addr_r;
    assign ctx_addr_vld = ctx_addr_vld_r;
    assign dec_run      = dec_run_r;
    assign ep_mode      = ep_mode_r;
    assign flag_out     = flag_out_r;
    assign idx_out      = idx_out_r;
    assign result_vld   = result_vld_r;
    assign done_intr    = done_intr_r;
    assign busy         = busy_r;

endmodule
